// File: rtl/multilane_sched_fsm_pkg.sv
// Opcode constants and enums shared by the schedule controller and its testbench.
// Mode values equal the opcode encodings, so a latched opcode casts directly to a mode.
package multilane_sched_fsm_pkg;

   localparam logic [1:0] OP_NTT  = 2'd0;
   localparam logic [1:0] OP_PWM0 = 2'd1;
   localparam logic [1:0] OP_PWM1 = 2'd2;
   localparam logic [1:0] OP_INTT = 2'd3;

   typedef enum logic [1:0] {
      MODE_NTT  = 2'd0,
      MODE_PWM0 = 2'd1,
      MODE_PWM1 = 2'd2,
      MODE_INTT = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   function automatic logic is_pwm(input mode_e m);
      return (m == MODE_PWM0) || (m == MODE_PWM1);
   endfunction

endpackage

// File: rtl/multilane_sched_fsm_if.sv
// Command/strobe bundle between the command front-end (master) and the schedule controller (slave).
// The i/s widths are derived from the geometry parameters.
interface multilane_sched_fsm_if #(
   parameter int STAGES = 7,
   parameter int GROUPS = 128
);
   localparam int IW = $clog2(STAGES);
   localparam int SW = $clog2(GROUPS);

   logic [1:0]    opcode;
   logic          start;
   logic          stall;
   logic          abort;
   logic [IW-1:0] i;
   logic [SW-1:0] s;
   logic          ren;
   logic          wen;
   logic          en;
   logic          busy;
   logic          finish;

   modport master (
      output opcode, start, stall, abort,
      input  i, s, ren, wen, en, busy, finish
   );

   modport slave (
      input  opcode, start, stall, abort,
      output i, s, ren, wen, en, busy, finish
   );
endinterface

// File: rtl/multilane_sched_fsm_pipe_delay.sv
// Fixed-depth shift register with synchronous clear; output is the input delayed DEPTH cycles.
// No back-pressure: it shifts every cycle, and a clear empties every stage at once.
module multilane_sched_fsm_pipe_delay #(
   parameter int DEPTH = 2,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic [W-1:0] dat_i,
   output logic [W-1:0] dat_o
);
   logic [W-1:0] sr_q [DEPTH];

   always_ff @(posedge clk) begin
      if (clr_i) begin
         for (int k = 0; k < DEPTH; k++) sr_q[k] <= '0;
      end else begin
         sr_q[0] <= dat_i;
         for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
      end
   end

   assign dat_o = sr_q[DEPTH-1];
endmodule

// File: rtl/multilane_sched_fsm.sv
// Schedule controller: issues (stage, group) tuples, delayed ren/wen strobes and a finish pulse.
// First issue 1 cycle after start; ren/wen trail issue by RD_LAT/WR_LAT; stall inserts a bubble.
module multilane_sched_fsm
   import multilane_sched_fsm_pkg::*;
#(
   parameter int STAGES  = 7,
   parameter int GROUPS  = 128,
   parameter int P       = 4,
   parameter int PWM_LEN = 64,
   parameter int RD_LAT  = 2,
   parameter int WR_LAT  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   multilane_sched_fsm_if.slave bus
);
   localparam int IW = $clog2(STAGES);
   localparam int SW = $clog2(GROUPS);

   state_e        state_q;
   mode_e         mode_q;
   logic [IW-1:0] i_q;
   logic [SW-1:0] s_q;
   logic          busy_q;

   logic issue_vld;
   logic last_tuple;
   logic pipe_clr;
   logic ren;
   logic wen;
   logic fin_tag;

   assign issue_vld = (state_q == ST_RUN) && !bus.stall;
   assign pipe_clr  = rst || bus.abort;

   always_comb begin
      last_tuple = 1'b0;
      case (mode_q)
         MODE_NTT:  last_tuple = (i_q == IW'(STAGES-1)) && (s_q == SW'(GROUPS-P));
         MODE_INTT: last_tuple = (i_q == '0) && (s_q == SW'(GROUPS-P));
         default:   last_tuple = (s_q == SW'(PWM_LEN-1));
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || bus.abort) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_NTT;
         i_q     <= '0;
         s_q     <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  mode_q  <= mode_e'(bus.opcode);
                  i_q     <= (bus.opcode == OP_INTT) ? IW'(STAGES-1) : '0;
                  s_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (issue_vld) begin
                  // The final tuple stays visible on i/s until the drain completes.
                  if (last_tuple) begin
                     state_q <= ST_DRAIN;
                  end else if (is_pwm(mode_q)) begin
                     s_q <= s_q + SW'(1);
                  end else if (s_q == SW'(GROUPS-P)) begin
                     s_q <= '0;
                     i_q <= (mode_q == MODE_INTT) ? i_q - IW'(1) : i_q + IW'(1);
                  end else begin
                     s_q <= s_q + SW'(P);
                  end
               end
            end
            ST_DRAIN: begin
               if (fin_tag) begin
                  state_q <= ST_IDLE;
                  i_q     <= '0;
                  s_q     <= '0;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   multilane_sched_fsm_pipe_delay #(.DEPTH(RD_LAT), .W(1)) u_rd_dly (
      .clk   (clk),
      .clr_i (pipe_clr),
      .dat_i (issue_vld),
      .dat_o (ren)
   );

   // The last-issue tag rides with the write strobe so finish lands on the final wen.
   multilane_sched_fsm_pipe_delay #(.DEPTH(WR_LAT), .W(2)) u_wr_dly (
      .clk   (clk),
      .clr_i (pipe_clr),
      .dat_i ({issue_vld, issue_vld && last_tuple}),
      .dat_o ({wen, fin_tag})
   );

   assign bus.i      = i_q;
   assign bus.s      = s_q;
   assign bus.ren    = ren;
   assign bus.wen    = wen;
   assign bus.en     = ren || wen;
   assign bus.busy   = busy_q;
   assign bus.finish = fin_tag;
endmodule

// File: tb/tb_multilane_sched_fsm.sv
// Randomised bench for multilane_sched_fsm against a per-cycle model built from issue lists.
module tb_multilane_sched_fsm;
   import multilane_sched_fsm_pkg::*;

   localparam int STAGES  = 7;
   localparam int GROUPS  = 128;
   localparam int P       = 4;
   localparam int PWM_LEN = 64;
   localparam int RD_LAT  = 2;
   localparam int WR_LAT  = 8;
   localparam int MAXC    = 16384;

   logic clk = 1'b0;
   logic rst;

   multilane_sched_fsm_if #(.STAGES(STAGES), .GROUPS(GROUPS)) bus ();

   multilane_sched_fsm #(
      .STAGES(STAGES), .GROUPS(GROUPS), .P(P), .PWM_LEN(PWM_LEN),
      .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Model: expected tuple list of the active operation, position in it, issue history per cycle.
   int  cyc_n  = 0;
   int  kill   = -1;
   bit  armed  = 1'b0;
   bit  m_busy = 1'b0;
   int  m_pos  = 0;
   int  m_n    = 0;
   int  m_last = -100;
   int  q_i[$];
   int  q_s[$];
   bit  vh[MAXC];
   bit  lh[MAXC];
   bit  obs_wen;
   bit  obs_fin;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc_n, got, exp);
      end
   endtask

   function automatic bit hist(input int c, input bit want_last);
      if (c < 0 || c <= kill) return 1'b0;
      return want_last ? lh[c] : vh[c];
   endfunction

   task automatic build(input bit [1:0] op);
      q_i.delete();
      q_s.delete();
      if (op == OP_PWM0 || op == OP_PWM1) begin
         for (int k = 0; k < PWM_LEN; k++) begin
            q_i.push_back(0);
            q_s.push_back(k);
         end
      end else begin
         for (int st = 0; st < STAGES; st++) begin
            for (int g = 0; g < GROUPS; g += P) begin
               q_i.push_back(op == OP_INTT ? STAGES - 1 - st : st);
               q_s.push_back(g);
            end
         end
      end
      m_n = q_i.size();
   endtask

   task automatic cyc(input bit r, input bit st, input bit [1:0] op, input bit sl, input bit ab);
      int ei, es;
      bit eren, ewen, efin, iss;
      if (cyc_n >= MAXC) begin
         $display("FAIL cycle_budget cyc=%0d got=%0d exp<%0d", cyc_n, cyc_n, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      rst        = r;
      bus.start  = st;
      bus.opcode = op;
      bus.stall  = sl;
      bus.abort  = ab;
      #3;
      obs_wen = (bus.wen === 1'b1);
      obs_fin = (bus.finish === 1'b1);
      if (armed) begin
         ei = 0;
         es = 0;
         if (m_busy) begin
            ei = q_i[(m_pos < m_n) ? m_pos : m_n - 1];
            es = q_s[(m_pos < m_n) ? m_pos : m_n - 1];
         end
         eren = hist(cyc_n - RD_LAT, 1'b0);
         ewen = hist(cyc_n - WR_LAT, 1'b0);
         efin = hist(cyc_n - WR_LAT, 1'b1);
         chk_val("i",      32'(bus.i),      32'(ei));
         chk_val("s",      32'(bus.s),      32'(es));
         chk_val("ren",    32'(bus.ren),    32'(eren));
         chk_val("wen",    32'(bus.wen),    32'(ewen));
         chk_val("en",     32'(bus.en),     32'(eren | ewen));
         chk_val("busy",   32'(bus.busy),   32'(m_busy));
         chk_val("finish", 32'(bus.finish), 32'(efin));
      end
      iss = m_busy && (m_pos < m_n) && !sl;
      vh[cyc_n] = iss;
      lh[cyc_n] = iss && (m_pos == m_n - 1);
      if (r || ab) begin
         kill   = cyc_n;
         m_busy = 1'b0;
         m_pos  = 0;
         if (r) armed = 1'b1;
      end else if (!m_busy) begin
         if (st) begin
            build(op);
            m_busy = 1'b1;
            m_pos  = 0;
         end
      end else if (iss) begin
         if (m_pos == m_n - 1) m_last = cyc_n;
         m_pos++;
      end else if (m_pos == m_n && cyc_n == m_last + WR_LAT) begin
         m_busy = 1'b0;
      end
      cyc_n++;
      @(posedge clk);
      #1;
   endtask

   // mode 0: no stall; 1: stall at relative cycles 10..14; 2: random stall/start/opcode noise.
   task automatic run(input bit [1:0] op, input int mode, input int abort_at, input int rst_at,
                      output int fin_rel, output int wen_cnt);
      int rel;
      bit st, sl;
      bit [1:0] o;
      fin_rel = -1;
      wen_cnt = 0;
      rel     = 0;
      do begin
         st = (rel == 0) || (mode == 2 && $urandom_range(0, 15) == 0) || (mode != 2 && rel % 37 == 5);
         o  = (rel == 0) ? op : 2'($urandom_range(0, 3));
         sl = (mode == 1 && rel >= 10 && rel <= 14) || (mode == 2 && $urandom_range(0, 3) == 0);
         cyc(rel == rst_at, st, o, sl, rel == abort_at);
         if (obs_wen) wen_cnt++;
         if (obs_fin) fin_rel = rel;
         rel++;
      end while (m_busy && rel < 3000);
      chk_val("idle_after_run", 32'(bus.busy), 32'd0);
   endtask

   int f, w;

   initial begin
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.opcode = 2'd0;
      bus.stall  = 1'b0;
      bus.abort  = 1'b0;
      @(posedge clk);
      #1;
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, $urandom_range(0, 1), 0);

      run(OP_NTT, 0, -1, -1, f, w);
      chk_val("ntt_finish_rel", f, 232);
      chk_val("ntt_wen_count",  w, 224);

      run(OP_INTT, 0, -1, -1, f, w);
      chk_val("intt_finish_rel", f, 232);
      chk_val("intt_wen_count",  w, 224);

      run(OP_PWM1, 1, -1, -1, f, w);
      chk_val("pwm1_stall_finish_rel", f, 77);
      chk_val("pwm1_stall_wen_count",  w, 64);

      run(OP_NTT, 0, 50, -1, f, w);
      chk_val("abort_finish_rel", f, -1);
      chk_val("abort_wen_count",  w, 42);
      repeat (12) cyc(0, 0, 0, 0, 0);

      run(OP_PWM0, 0, -1, 30, f, w);
      chk_val("rst_finish_rel", f, -1);
      repeat (12) cyc(0, 0, 0, 0, 0);

      for (int k = 0; k < 10; k++) begin
         run(2'($urandom_range(0, 3)), 2,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 250)) : -1,
             ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 250)) : -1, f, w);
         repeat ($urandom_range(0, 4)) cyc(0, 0, 2'($urandom_range(0, 3)), $urandom_range(0, 1), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/multilane_sched_fsm.md
# multilane_sched_fsm

Parametrised schedule controller for the multi-lane NTT/INTT/PWM datapath. It generates the (stage, group) address tuple every cycle, the read/write/bank-enable strobes aligned to the butterfly pipeline, and a completion pulse. Compared with the previous controller it adds configurable geometry and latencies, a latched opcode, a stall (back-pressure) input, an abort input, and a busy/finish handshake. It sits between the top-level command interface and the bank address generators / butterfly array.

## Interface
- STAGES, 7, number of NTT/INTT stages; stage index range 0..STAGES-1
- GROUPS, 128, group-index space per stage; must be a multiple of P
- P, 4, parallel lanes; group index advances by P per issue in NTT/INTT
- PWM_LEN, 64, issues per PWM pass (group index steps by 1, stage fixed at 0)
- RD_LAT, 2, issue-to-ren delay in cycles (≥1)
- WR_LAT, 8, issue-to-wen delay in cycles (>RD_LAT)
- IW, $clog2(STAGES); SW, $clog2(GROUPS) (derived, not overridable)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- opcode  in  2  operation; sampled only when start is accepted
- start  in  1  request pulse; accepted only while busy=0
- stall  in  1  freeze issue this cycle (no advance, bubble inserted)
- abort  in  1  cancel current operation; no finish generated
- i  out  IW  current stage index
- s  out  SW  current group index
- ren  out  1  bank read strobe (issue delayed RD_LAT)
- wen  out  1  bank write strobe (issue delayed WR_LAT)
- en  out  1  bank enable = ren | wen
- busy  out  1  operation in progress
- finish  out  1  one-cycle pulse, coincident with the final wen

## Operation
- Opcodes: NTT=2'd0, PWM0=2'd1, PWM1=2'd2, INTT=2'd3.
- States: IDLE, RUN, DRAIN.
- IDLE: i=0, s=0, busy=0. start=1 → latch opcode into mode, load i = (INTT ? STAGES-1 : 0), s=0, go RUN.
- RUN: each cycle with stall=0 is an issue (internal valid=1) of the current (i,s); then advance:
  - NTT/INTT: s += P; when s == GROUPS-P, s←0 and i steps (+1 NTT, −1 INTT).
  - PWM0/PWM1: s += 1, i stays 0.
  - Last tuple (NTT: i=STAGES-1, s=GROUPS-P; INTT: i=0, s=GROUPS-P; PWM: s=PWM_LEN-1) → go DRAIN, i/s hold last value.
- stall=1 in RUN: valid=0, i/s held. stall ignored in IDLE/DRAIN.
- DRAIN: wait until the last issue emerges from the WR_LAT delay; finish=1 that cycle, next state IDLE.
- Issue counts: NTT/INTT = STAGES·GROUPS/P (224 default), PWM = PWM_LEN (64).
- abort=1 (any state): next cycle IDLE, i=s=0, both delay lines cleared, no finish. abort wins over start.
- start while busy=1: ignored, not queued. opcode changes outside acceptance: no effect.

## Timing
- Reset values: i=0, s=0, ren=0, wen=0, en=0, busy=0, finish=0, state IDLE; delay lines cleared.
- start sampled high at edge k → busy=1 and first issue at cycle k+1.
- Issue at cycle t → ren at t+RD_LAT, wen at t+WR_LAT; bubbles from stall propagate identically.
- finish at (last issue)+WR_LAT; busy=1 through that cycle, 0 the cycle after.
- New start accepted at the first cycle busy=0 (earliest: cycle after finish).
- Unstalled NTT with start at 0: issues 1..224, finish at 232, busy high 1..232.

## Structure
- Shared package: opcode constants, mode enum, state enum.
- Sub-module pipe_delay: parametrised depth/width shift register with synchronous clear; two instances (RD_LAT, WR_LAT) driven by internal valid, with last-issue tag carried in the WR_LAT instance for finish.

## Test plan
- NTT, defaults, no stall: start at cycle 0 → i=0,s=0 at 1; i=1,s=0 at 33; i=6,s=124 at 224; 224 wen pulses; finish only at 232.
- INTT: i starts at 6, descends to 0; last tuple (0,124); finish at 232.
- PWM1 with stall high cycles 10–14: s holds 9 for 5 cycles, ren/wen show 5-cycle gap; finish at 64+5+8=77.
- abort at cycle 50 of NTT: cycle 51 busy=0, i=s=0, no further ren/wen, finish never asserted.
- start re-pulsed while busy and opcode toggled mid-run: no effect on sequence; start at finish+1 accepted with new opcode.
- rst asserted mid-RUN: next cycle all outputs at reset values, no residual strobes.
